arbitro_ula: RTL

ARBITRO_ULA -- requirements
Module: arbitro_ula

---
 rtl/arbitro_ula.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/arbitro_ula.sv
// Two-requester arbiter sharing one 4-bit ALU: IDLE -> EXEC -> RESP, result held until owner ack or timeout.
// Optional macro ARBITRO_ULA_PRIO_FIXA_EN selects fixed priority (requester 0 wins ties) instead of round-robin.

module ula_4b (
    input  logic [2:0] func_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] y_o,
    output logic       ill_o
);
    always_comb begin
        y_o   = 4'b0000;
        ill_o = 1'b0;
        case (func_i)
            3'b000:  y_o = a_i + b_i;
            3'b001:  y_o = a_i - b_i;
            3'b010:  y_o = {3'b000, (a_i > b_i)};
            3'b011:  y_o = {3'b000, (a_i < b_i)};
            3'b100:  y_o = {3'b000, (a_i == b_i)};
            3'b101:  y_o = a_i ^ b_i;
            3'b110:  y_o = a_i & b_i;
            default: ill_o = 1'b1;
        endcase
    end
endmodule

module arbitro_ula #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] func0,
    input  logic [2:0] func1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       ack0,
    input  logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] res,
    output logic       res_valid,
    output logic       res_id,
    output logic       busy,
    output logic       ill_op,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] res_q, res_d;
    logic       res_valid_q, res_valid_d;
    logic       res_id_q, res_id_d;
    logic       ill_q, ill_d;
    logic       tmo_q, tmo_d;
    logic [2:0] func_q;
    logic [3:0] a_q, b_q;
    logic       id_q;
    logic [3:0] alu_y;
    logic       alu_ill;
    logic       ack_own;
    logic       any_gnt;

`ifdef ARBITRO_ULA_PRIO_FIXA_EN
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state_q == IDLE) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end
`else
    // last_q holds the id granted most recently; the other requester wins a tie
    logic last_q, last_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0 || gnt1) last_d = gnt1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    assign any_gnt = gnt0 | gnt1;
    assign ack_own = res_id_q ? ack1 : ack0;

    ula_4b u_ula (
        .func_i (func_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .y_o    (alu_y),
        .ill_o  (alu_ill)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        ill_d       = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_gnt) state_d = EXEC;
            end
            EXEC: begin
                state_d     = RESP;
                res_d       = alu_y;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                ill_d       = alu_ill;
                cnt_d       = 4'd0;
            end
            RESP: begin
                // an ack arriving on the last counted cycle still wins over the timeout
                if (ack_own) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    tmo_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            res_q       <= 4'd0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            ill_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            ill_q       <= ill_d;
            tmo_q       <= tmo_d;
        end
    end

    // operand capture is pure data and only meaningful after a grant
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            func_q <= gnt1 ? func1 : func0;
            a_q    <= gnt1 ? a1 : a0;
            b_q    <= gnt1 ? b1 : b0;
            id_q   <= gnt1;
        end
    end

    assign res         = res_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign busy        = (state_q != IDLE);
    assign ill_op      = ill_q;
    assign timeout_err = tmo_q;
endmodule
